// File: rtl/ram4k_loader.sv
// Bulk loader for a 2^ADDR_W x DATA_W RAM: streams words in, then reads the region
// back and compares additive checksums of both passes.
module ram4k_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_count,
    input  logic              i_s_valid,
    input  logic [DATA_W-1:0] i_s_data,
    output logic              o_s_ready,
    output logic [DATA_W-1:0] o_ram_in,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_load,
    input  logic [DATA_W-1:0] i_ram_out,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [DATA_W-1:0] o_checksum
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WRITE  = 2'd1;
    localparam logic [1:0] S_VERIFY = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_remain;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_wsum;
    logic [DATA_W-1:0] r_rsum;
    logic              r_error;
    logic [DATA_W-1:0] r_checksum;

    logic [ADDR_W:0]   w_count_clamped;
    logic              w_accept;

    assign w_count_clamped = (i_count > MAX_CNT) ? MAX_CNT : i_count;
    assign w_accept        = (r_state == S_WRITE) && i_s_valid;

    assign o_s_ready  = (r_state == S_WRITE);
    assign o_ram_load = w_accept;
    assign o_ram_in   = (r_state == S_WRITE) ? i_s_data : '0;
    assign o_ram_addr = r_addr;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_error    = r_error;
    assign o_checksum = r_checksum;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_base     <= '0;
            r_remain   <= '0;
            r_count    <= '0;
            r_wsum     <= '0;
            r_rsum     <= '0;
            r_error    <= 1'b0;
            r_checksum <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_base   <= i_base_addr;
                        r_addr   <= i_base_addr;
                        r_count  <= w_count_clamped;
                        r_remain <= w_count_clamped;
                        r_wsum   <= '0;
                        r_rsum   <= '0;
                        r_error  <= 1'b0;
                        r_state  <= (w_count_clamped != '0) ? S_WRITE : S_DONE;
                    end
                end
                S_WRITE: begin
                    if (w_accept) begin
                        r_wsum <= r_wsum + i_s_data;
                        // Last word: rewind to the start of the region for readback.
                        if (r_remain == 1) begin
                            r_addr   <= r_base;
                            r_remain <= r_count;
                            r_state  <= S_VERIFY;
                        end else begin
                            r_addr   <= r_addr + 1'b1;
                            r_remain <= r_remain - 1'b1;
                        end
                    end
                end
                S_VERIFY: begin
                    r_rsum   <= r_rsum + i_ram_out;
                    r_addr   <= r_addr + 1'b1;
                    r_remain <= r_remain - 1'b1;
                    if (r_remain == 1) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_error    <= (r_wsum != r_rsum);
                    r_checksum <= r_wsum;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram4k_loader.sv
// Directed bench for ram4k_loader with a behavioural 4K x 16 RAM that can corrupt one read address.
module tb_ram4k_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] count;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic [15:0] ram_in;
    logic [11:0] ram_addr;
    logic        ram_load;
    logic [15:0] ram_out;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] checksum;

    ram4k_loader dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_count     (count),
        .i_s_valid   (s_valid),
        .i_s_data    (s_data),
        .o_s_ready   (s_ready),
        .o_ram_in    (ram_in),
        .o_ram_addr  (ram_addr),
        .o_ram_load  (ram_load),
        .i_ram_out   (ram_out),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (error),
        .o_checksum  (checksum)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:4095];
    logic        corrupt_en = 1'b0;
    logic [11:0] corrupt_addr = '0;
    logic [15:0] corrupt_val = '0;
    logic [11:0] wr_addr_log [$];
    logic [15:0] wr_data_log [$];

    assign ram_out = (corrupt_en && ram_addr == corrupt_addr) ? corrupt_val : mem[ram_addr];

    always @(posedge clk) begin
        if (ram_load) begin
            mem[ram_addr] <= ram_in;
            wr_addr_log.push_back(ram_addr);
            wr_data_log.push_back(ram_in);
        end
    end

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] stream [0:4095];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation: start, then feed stream[] until done or a cycle budget expires.
    task automatic do_op(input logic [11:0] base, input logic [12:0] cnt, input int n_words,
                         input bit stall, input bit extra_start,
                         output int done_cyc, output int ready_cnt);
        int idx = 0;
        int cyc = 1;
        done_cyc  = -1;
        ready_cnt = 0;
        wr_addr_log.delete();
        wr_data_log.delete();
        start     = 1'b1;
        base_addr = base;
        count     = cnt;
        s_valid   = 1'b0;
        tick();
        start = 1'b0;
        while (cyc < 10000) begin
            start   = (extra_start && cyc == 2);
            if (start) begin
                base_addr = 12'h700;
                count     = 13'd5;
            end
            s_valid = (idx < n_words) && (!stall || cyc[0]);
            s_data  = stream[idx % 4096];
            #1;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (s_ready) ready_cnt++;
            if (s_valid && s_ready) idx++;
            tick();
            cyc++;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        if (done_cyc < 0) check("timeout_waiting_done", 32'(cyc), 32'd0);
    endtask

    int dc, rc;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; s_valid = 1'b0; s_data = '0;
        tick(); tick();
        #1;
        check("rst_s_ready", s_ready, 0);
        check("rst_ram_load", ram_load, 0);
        check("rst_ram_in", ram_in, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_checksum", checksum, 0);
        reset_n = 1'b1;
        tick();

        // Contiguous write of four words
        stream[0] = 16'habcd; stream[1] = 16'habce; stream[2] = 16'habcf; stream[3] = 16'habd0;
        do_op(12'h000, 13'd4, 4, 1'b0, 1'b0, dc, rc);
        check("t1_done_cycle", dc, 9);
        check("t1_busy_at_done", busy, 1);
        check("t1_write_count", wr_addr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < wr_addr_log.size()) begin
                check($sformatf("t1_waddr%0d", i), wr_addr_log[i], i);
                check($sformatf("t1_wdata%0d", i), wr_data_log[i], stream[i]);
            end
        end
        tick();
        check("t1_checksum", checksum, 16'haf3a);
        check("t1_error", error, 0);
        check("t1_busy_after", busy, 0);

        // Address wrap with alternating valid
        stream[0] = 16'h1234; stream[1] = 16'h5678; stream[2] = 16'h9abc; stream[3] = 16'hdef0;
        do_op(12'hffe, 13'd4, 4, 1'b1, 1'b0, dc, rc);
        check("t2_done_cycle", dc, 12);
        check("t2_ready_cycles", rc, 7);
        check("t2_write_count", wr_addr_log.size(), 4);
        if (wr_addr_log.size() == 4) begin
            check("t2_waddr0", wr_addr_log[0], 12'hffe);
            check("t2_waddr1", wr_addr_log[1], 12'hfff);
            check("t2_waddr2", wr_addr_log[2], 12'h000);
            check("t2_waddr3", wr_addr_log[3], 12'h001);
        end
        tick();
        check("t2_checksum", checksum, 16'he258);
        check("t2_error", error, 0);
        check("t2_mem_000", mem[0], 16'h9abc);

        // Readback corruption at the second address
        stream[0] = 16'h1111; stream[1] = 16'h2222;
        corrupt_addr = 12'h101; corrupt_val = 16'h2223; corrupt_en = 1'b1;
        do_op(12'h100, 13'd2, 2, 1'b0, 1'b0, dc, rc);
        check("t3_done_cycle", dc, 5);
        check("t3_error_at_done", error, 0);
        tick();
        corrupt_en = 1'b0;
        check("t3_checksum", checksum, 16'h3333);
        check("t3_error", error, 1);

        // Zero count; error clears on the accepting start
        do_op(12'h050, 13'd0, 0, 1'b0, 1'b0, dc, rc);
        check("t4_done_cycle", dc, 1);
        check("t4_error_cleared", error, 0);
        check("t4_write_count", wr_addr_log.size(), 0);
        tick();
        check("t4_checksum", checksum, 0);

        // Second start during WRITE is ignored
        stream[0] = 16'h0001; stream[1] = 16'h0002; stream[2] = 16'h0003;
        do_op(12'h200, 13'd3, 3, 1'b0, 1'b1, dc, rc);
        check("t5_done_cycle", dc, 7);
        check("t5_write_count", wr_addr_log.size(), 3);
        if (wr_addr_log.size() == 3) check("t5_waddr2", wr_addr_log[2], 12'h202);
        tick();
        check("t5_checksum", checksum, 16'h0006);

        // Reset after two of eight words
        for (int k = 0; k < 8; k++) stream[k] = 16'((k + 1) * 16'h1001);
        wr_addr_log.delete();
        start = 1'b1; base_addr = 12'h300; count = 13'd8;
        tick();
        start = 1'b0;
        s_valid = 1'b1; s_data = stream[0];
        tick();
        s_data = stream[1];
        tick();
        s_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_s_ready", s_ready, 0);
        check("t6_ram_addr", ram_addr, 0);
        check("t6_ram_in", ram_in, 0);
        check("t6_partial_writes", wr_addr_log.size(), 2);
        tick();
        check("t6_no_done_after", done, 0);
        do_op(12'h300, 13'd8, 8, 1'b0, 1'b0, dc, rc);
        check("t6_done_cycle", dc, 17);
        tick();
        check("t6_checksum", checksum, 16'h4024);
        check("t6_error", error, 0);

        // Oversized count clamps to the full 4096-word region
        for (int k = 0; k < 4096; k++) stream[k] = 16'(k);
        do_op(12'h000, 13'd5000, 4096, 1'b0, 1'b0, dc, rc);
        check("t7_done_cycle", dc, 8193);
        check("t7_write_count", wr_addr_log.size(), 4096);
        tick();
        check("t7_checksum", checksum, 16'hf800);
        check("t7_error", error, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
